// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared state encodings and sizing constants for the shift-add multiplier controller
package mul_pkg;

  // Raw 3-bit encodings, kept as localparams so other blocks can decode state bits directly
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_EXAM  = 3'd2;
  localparam logic [2:0] ST_ADD   = 3'd3;
  localparam logic [2:0] ST_SHIFT = 3'd4;
  localparam logic [2:0] ST_CAPT  = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_LOAD  = ST_LOAD,
    S_EXAM  = ST_EXAM,
    S_ADD   = ST_ADD,
    S_SHIFT = ST_SHIFT,
    S_CAPT  = ST_CAPT,
    S_DONE  = ST_DONE
  } mul_state_t;

  // Operand width of the matching datapath
  localparam int MUL_WIDTH_DEFAULT = 4;

  // Cycle counter used when MUL_CTRL_PERF_EN is defined
  localparam int         PERF_W   = 8;
  localparam logic [7:0] PERF_MAX = 8'hFF;

endpackage

// File: rtl/mul_iter_counter.sv
// rtl/mul_iter_counter.sv - shift iteration counter with clear/increment and last-iteration flag
module mul_iter_counter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  // Clear wins over increment; the controller never asserts both together
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Flags the shift that completes the final iteration
  assign last = (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mul_shift_add_ctrl.sv
// rtl/mul_shift_add_ctrl.sv - shift-add multiplier control FSM with result handshake; MUL_CTRL_PERF_EN adds a cycle counter
module mul_shift_add_ctrl
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               start_ready,
  input  logic               m0,
  input  logic [2*WIDTH-1:0] product_in,
  output logic               Load,
  output logic               Add,
  output logic               Shift,
  output logic               busy,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*WIDTH-1:0] result,
  output logic [7:0]         last_cycles
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  mul_state_t       state;
  logic [CNT_W-1:0] iter_cnt;
  logic             iter_last;
  logic             iter_clr;
  logic             iter_inc;

  // Counter resets on LOAD and advances once per SHIFT cycle
  assign iter_clr = (state == S_LOAD);
  assign iter_inc = (state == S_SHIFT);

  mul_iter_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk   (clk),
    .reset (reset),
    .clr   (iter_clr),
    .inc   (iter_inc),
    .cnt   (iter_cnt),
    .last  (iter_last)
  );

  // Sequencer: outputs are registered alongside the state so each strobe is glitch-free
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      start_ready <= 1'b1;
      Load        <= 1'b0;
      Add         <= 1'b0;
      Shift       <= 1'b0;
      busy        <= 1'b0;
      res_valid   <= 1'b0;
      result      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_LOAD;
            start_ready <= 1'b0;
            busy        <= 1'b1;
            Load        <= 1'b1;
          end
        end
        S_LOAD: begin
          state <= S_EXAM;
          Load  <= 1'b0;
        end
        S_EXAM: begin
          // Datapath has settled the multiplier LSB for this iteration
          if (m0) begin
            state <= S_ADD;
            Add   <= 1'b1;
          end else begin
            state <= S_SHIFT;
            Shift <= 1'b1;
          end
        end
        S_ADD: begin
          state <= S_SHIFT;
          Add   <= 1'b0;
          Shift <= 1'b1;
        end
        S_SHIFT: begin
          Shift <= 1'b0;
          if (iter_last) begin
            state <= S_CAPT;
          end else begin
            state <= S_EXAM;
          end
        end
        S_CAPT: begin
          // Product register already holds the post-final-shift value
          result    <= product_in;
          state     <= S_DONE;
          busy      <= 1'b0;
          res_valid <= 1'b1;
        end
        S_DONE: begin
          // A start seen here is dropped; the requester must retry from IDLE
          if (res_ready) begin
            state       <= S_IDLE;
            res_valid   <= 1'b0;
            start_ready <= 1'b1;
          end
        end
        default: begin
          state       <= S_IDLE;
          start_ready <= 1'b1;
          Load        <= 1'b0;
          Add         <= 1'b0;
          Shift       <= 1'b0;
          busy        <= 1'b0;
          res_valid   <= 1'b0;
        end
      endcase
    end
  end

`ifdef MUL_CTRL_PERF_EN
  logic [PERF_W-1:0] perf_cnt;
  logic [PERF_W-1:0] last_cycles_q;

  // Counts active cycles of the current op; snapshot taken as CAPT hands over to DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_cnt      <= '0;
      last_cycles_q <= '0;
    end else begin
      if (state == S_IDLE) begin
        if (start) begin
          perf_cnt <= '0;
        end
      end else if (state != S_DONE) begin
        if (perf_cnt != PERF_MAX) begin
          perf_cnt <= perf_cnt + 1'b1;
        end
      end
      if (state == S_CAPT) begin
        last_cycles_q <= perf_cnt;
      end
    end
  end

  assign last_cycles = last_cycles_q;
`else
  assign last_cycles = 8'd0;
`endif

  strobe_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0({Load, Add, Shift}));

  iter_cnt_bound: assert property (@(posedge clk) disable iff (reset)
    iter_cnt <= CNT_W'(WIDTH));

endmodule

// File: tb/tb_mul_shift_add_ctrl.sv
// tb/tb_mul_shift_add_ctrl.sv - directed bench for the shift-add controller driving a behavioural datapath
module tb_mul_shift_add_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       start_ready;
  logic       m0;
  logic [7:0] product_in;
  logic       Load, Add, Shift;
  logic       busy;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] result;
  logic [7:0] last_cycles;

  logic [3:0] mcand = 4'd0;
  logic [3:0] mplier = 4'd0;
  logic [8:0] acc;

  int n_checks = 0;
  int n_fail = 0;
  int add_cnt = 0;
  int shift_cnt = 0;

  always #5 clk = ~clk;

  mul_shift_add_ctrl #(.WIDTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .start_ready (start_ready),
    .m0          (m0),
    .product_in  (product_in),
    .Load        (Load),
    .Add         (Add),
    .Shift       (Shift),
    .busy        (busy),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .last_cycles (last_cycles)
  );

  // Behavioural 4-bit shift-add datapath: {carry, high, multiplier} register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) acc <= '0;
    else if (Load) acc <= {5'b0, mplier};
    else if (Add) acc <= {({1'b0, acc[7:4]} + {1'b0, mcand}), acc[3:0]};
    else if (Shift) acc <= acc >> 1;
  end
  assign m0 = acc[0];
  assign product_in = acc[7:0];

  // Strobe exclusivity and pulse counting every cycle
  always @(negedge clk) begin
    n_checks++;
    assert ($onehot0({Load, Add, Shift})) else begin
      n_fail++;
      $error("FAIL strobe_onehot observed=%b required=onehot0", {Load, Add, Shift});
    end
    if (Add) add_cnt++;
    if (Shift) shift_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s observed=%0d required=%0d", tag, observed, expected);
    end
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input int exp_lat,
                        input int exp_adds, input string tag);
    int lat;
    @(negedge clk);
    mcand = a;
    mplier = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    add_cnt = 0;
    shift_cnt = 0;
    check({tag, "_accepted"}, {31'd0, start_ready}, 32'd0);
    lat = 0;
    while (!res_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_result"}, {24'd0, result}, 32'(a) * 32'(b));
    check({tag, "_adds"}, add_cnt, exp_adds);
    check({tag, "_shifts"}, shift_cnt, 32'd4);
    check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic ack(input string tag);
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check({tag, "_ack_valid"}, {31'd0, res_valid}, 32'd0);
    check({tag, "_ack_ready"}, {31'd0, start_ready}, 32'd1);
  endtask

  initial begin
    int sh;
    int cyc;
    logic [3:0] ra, rb;

    // Reset state
    #12;
    check("rst_start_ready", {31'd0, start_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_result", {24'd0, result}, 32'd0);
    check("rst_strobes", {29'd0, Load, Add, Shift}, 32'd0);
    check("rst_last_cycles", {24'd0, last_cycles}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // 3x5
    run_op(4'd3, 4'd5, 12, 2, "op3x5");
`ifdef MUL_CTRL_PERF_EN
    check("perf_3x5", {24'd0, last_cycles}, 32'd11);
`else
    check("perf_off_3x5", {24'd0, last_cycles}, 32'd0);
`endif

    // Hold DONE with res_ready low while start is requested
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("hold_valid", {31'd0, res_valid}, 32'd1);
      check("hold_result", {24'd0, result}, 32'd15);
      check("hold_strobes", {29'd0, Load, Add, Shift}, 32'd0);
      check("hold_ready", {31'd0, start_ready}, 32'd0);
    end
    start = 1'b0;
    ack("op3x5");
    @(posedge clk); #1;
    check("start_lost_idle", {31'd0, start_ready}, 32'd1);

    // Boundary operands
    run_op(4'd15, 4'd15, 14, 4, "op15x15");
    ack("op15x15");
    run_op(4'd0, 4'd0, 10, 0, "op0x0");
    ack("op0x0");

    // Reset during the third SHIFT of 7x9
    @(negedge clk);
    mcand = 4'd7;
    mplier = 4'd9;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sh = 0;
    cyc = 0;
    while (sh < 3 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (Shift) sh++;
    end
    check("third_shift_seen", sh, 32'd3);
    reset = 1'b1;
    #1;
    check("midrst_strobes", {29'd0, Load, Add, Shift}, 32'd0);
    check("midrst_ready", {31'd0, start_ready}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_result", {24'd0, result}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op(4'd7, 4'd9, 12, 2, "op7x9");
    ack("op7x9");

    // Back-to-back with start held high and the consumer always ready
    @(negedge clk);
    ra = 4'($urandom_range(0, 15));
    rb = 4'($urandom_range(0, 15));
    mcand = ra;
    mplier = rb;
    start = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cyc = 0;
      while (!res_valid && cyc < 40) begin
        @(posedge clk); #1;
        cyc++;
      end
      check("b2b_seen", {31'd0, res_valid}, 32'd1);
      check("b2b_result", {24'd0, result}, 32'(ra) * 32'(rb));
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      mcand = ra;
      mplier = rb;
      @(posedge clk); #1;
      check("b2b_idle_gap", {31'd0, start_ready}, 32'd1);
    end
    start = 1'b0;
    @(posedge clk); #1;
    cyc = 0;
    while (!res_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    res_ready = 1'b0;
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
